// File: rtl/ddr_arb_pkg.sv
// Shared types for the two-port DDR arbiter: FSM state encoding and data width.
package ddr_arb_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    WRESP = 3'd3,
    RDATA = 3'd4
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way winner select: a lone requester wins; on contention
// either m0 wins outright (FIXED_PRIO) or the port that did not win last time.
module rr_arbiter2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner,
  output logic       any_req
);

  always_comb begin
    any_req = |req;
    winner  = 1'b0;
    case (req)
      2'b10:   winner = 1'b1;
      2'b11:   winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares the DDR controller's single transaction port between two requesters,
// one whole transaction at a time; only the address is registered.
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_BITS  = 26,
  parameter int FIXED_PRIO = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_arw_valid,
  output logic                 m0_arw_ready,
  input  logic [ADDR_BITS-1:0] m0_arw_addr,
  input  logic [7:0]           m0_arw_len,
  input  logic                 m0_arw_write,
  input  logic                 m0_wvalid,
  output logic                 m0_wready,
  input  logic                 m0_wlast,
  input  logic [DATA_W-1:0]    m0_wdata,
  output logic                 m0_bvalid,
  input  logic                 m0_bready,
  output logic                 m0_rvalid,
  input  logic                 m0_rready,
  output logic                 m0_rlast,
  output logic [DATA_W-1:0]    m0_rdata,
  input  logic                 m1_arw_valid,
  output logic                 m1_arw_ready,
  input  logic [ADDR_BITS-1:0] m1_arw_addr,
  input  logic [7:0]           m1_arw_len,
  input  logic                 m1_arw_write,
  input  logic                 m1_wvalid,
  output logic                 m1_wready,
  input  logic                 m1_wlast,
  input  logic [DATA_W-1:0]    m1_wdata,
  output logic                 m1_bvalid,
  input  logic                 m1_bready,
  output logic                 m1_rvalid,
  input  logic                 m1_rready,
  output logic                 m1_rlast,
  output logic [DATA_W-1:0]    m1_rdata,
  output logic                 ctrl_arw_valid,
  input  logic                 ctrl_arw_ready,
  output logic [ADDR_BITS-1:0] ctrl_arw_addr,
  output logic [7:0]           ctrl_arw_len,
  output logic                 ctrl_arw_write,
  output logic                 ctrl_arw_id,
  output logic                 ctrl_wvalid,
  input  logic                 ctrl_wready,
  output logic                 ctrl_wlast,
  output logic [DATA_W-1:0]    ctrl_wdata,
  input  logic                 ctrl_bvalid,
  output logic                 ctrl_bready,
  input  logic                 ctrl_rvalid,
  output logic                 ctrl_rready,
  input  logic                 ctrl_rlast,
  input  logic [DATA_W-1:0]    ctrl_rdata
);

  arb_state_t             state_reg;
  logic                   grant_reg;
  logic                   last_grant_reg;
  logic [7:0]             beat_cnt_reg;
  logic [ADDR_BITS-1:0]   req_addr_reg;
  logic [7:0]             req_len_reg;
  logic                   req_write_reg;
  logic                   post_reset_reg;

  // Per-port views so the steering logic can be written once per port.
  logic [1:0]             arw_valid_v;
  logic [ADDR_BITS-1:0]   arw_addr_v  [2];
  logic [7:0]             arw_len_v   [2];
  logic [1:0]             arw_write_v;
  logic [1:0]             wvalid_v;
  logic [1:0]             wlast_v;
  logic [DATA_W-1:0]      wdata_v     [2];
  logic [1:0]             bready_v;
  logic [1:0]             rready_v;
  logic [1:0]             arw_ready_v;
  logic [1:0]             wready_v;
  logic [1:0]             bvalid_v;
  logic [1:0]             rvalid_v;
  logic [1:0]             rlast_v;

  assign arw_valid_v   = {m1_arw_valid, m0_arw_valid};
  assign arw_addr_v[0] = m0_arw_addr;
  assign arw_addr_v[1] = m1_arw_addr;
  assign arw_len_v[0]  = m0_arw_len;
  assign arw_len_v[1]  = m1_arw_len;
  assign arw_write_v   = {m1_arw_write, m0_arw_write};
  assign wvalid_v      = {m1_wvalid, m0_wvalid};
  assign wlast_v       = {m1_wlast, m0_wlast};
  assign wdata_v[0]    = m0_wdata;
  assign wdata_v[1]    = m1_wdata;
  assign bready_v      = {m1_bready, m0_bready};
  assign rready_v      = {m1_rready, m0_rready};

  logic winner;
  logic any_req;

  rr_arbiter2 #(.FIXED_PRIO(FIXED_PRIO)) u_sel (
    .req        (arw_valid_v),
    .last_grant (last_grant_reg),
    .winner     (winner),
    .any_req    (any_req)
  );

  // State decodes are forced low during reset so no handshake leaks out.
  logic st_idle, st_addr, st_wdata, st_wresp, st_rdata, accept_ok;
  assign st_idle   = (state_reg == IDLE)  && !reset;
  assign st_addr   = (state_reg == ADDR)  && !reset;
  assign st_wdata  = (state_reg == WDATA) && !reset;
  assign st_wresp  = (state_reg == WRESP) && !reset;
  assign st_rdata  = (state_reg == RDATA) && !reset;
  assign accept_ok = st_idle && !post_reset_reg && any_req;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      wire is_granted = (grant_reg == 1'(gi));
      assign arw_ready_v[gi] = accept_ok && arw_valid_v[gi] && (winner == 1'(gi));
      assign wready_v[gi]    = st_wdata && is_granted && ctrl_wready;
      assign bvalid_v[gi]    = st_wresp && is_granted && ctrl_bvalid;
      assign rvalid_v[gi]    = st_rdata && is_granted && ctrl_rvalid;
      assign rlast_v[gi]     = st_rdata && is_granted && ctrl_rvalid && ctrl_rlast;
    end
  endgenerate

  assign m0_arw_ready = arw_ready_v[0];
  assign m1_arw_ready = arw_ready_v[1];
  assign m0_wready    = wready_v[0];
  assign m1_wready    = wready_v[1];
  assign m0_bvalid    = bvalid_v[0];
  assign m1_bvalid    = bvalid_v[1];
  assign m0_rvalid    = rvalid_v[0];
  assign m1_rvalid    = rvalid_v[1];
  assign m0_rlast     = rlast_v[0];
  assign m1_rlast     = rlast_v[1];
  assign m0_rdata     = ctrl_rdata;
  assign m1_rdata     = ctrl_rdata;

  assign ctrl_arw_valid = st_addr;
  assign ctrl_arw_addr  = req_addr_reg;
  assign ctrl_arw_len   = req_len_reg;
  assign ctrl_arw_write = req_write_reg;
  assign ctrl_arw_id    = grant_reg;
  assign ctrl_wvalid    = st_wdata && wvalid_v[grant_reg];
  assign ctrl_wlast     = st_wdata && wlast_v[grant_reg];
  assign ctrl_wdata     = wdata_v[grant_reg];
  assign ctrl_bready    = st_wresp && bready_v[grant_reg];
  assign ctrl_rready    = st_rdata && rready_v[grant_reg];

  logic arw_fire, w_fire;
  assign arw_fire = |arw_ready_v;
  assign w_fire   = ctrl_wvalid && ctrl_wready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      beat_cnt_reg   <= 8'd0;
      req_addr_reg   <= '0;
      req_len_reg    <= 8'd0;
      req_write_reg  <= 1'b0;
      post_reset_reg <= 1'b1;
    end else begin
      post_reset_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (arw_fire) begin
            req_addr_reg  <= arw_addr_v[winner];
            req_len_reg   <= arw_len_v[winner];
            req_write_reg <= arw_write_v[winner];
            grant_reg     <= winner;
            beat_cnt_reg  <= 8'd0;
            state_reg     <= ADDR;
          end
        end
        ADDR: begin
          if (ctrl_arw_ready) state_reg <= req_write_reg ? WDATA : RDATA;
        end
        WDATA: begin
          // Stop at wlast or after len+1 beats, whichever comes first.
          if (w_fire) begin
            beat_cnt_reg <= beat_cnt_reg + 8'd1;
            if (ctrl_wlast || (beat_cnt_reg == req_len_reg)) state_reg <= WRESP;
          end
        end
        WRESP: begin
          if (ctrl_bvalid && ctrl_bready) begin
            last_grant_reg <= grant_reg;
            state_reg      <= IDLE;
          end
        end
        RDATA: begin
          if (ctrl_rvalid && ctrl_rlast) begin
            last_grant_reg <= grant_reg;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter: one round-robin instance and one
// fixed-priority instance driven by the same stimulus.
module tb_ddr_port_arbiter;

  localparam int AB = 26;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          m0_arw_valid, m0_arw_write, m0_wvalid, m0_wlast, m0_bready, m0_rready;
  logic [AB-1:0] m0_arw_addr;
  logic [7:0]    m0_arw_len;
  logic [31:0]   m0_wdata;
  logic          m1_arw_valid, m1_arw_write, m1_wvalid, m1_wlast, m1_bready, m1_rready;
  logic [AB-1:0] m1_arw_addr;
  logic [7:0]    m1_arw_len;
  logic [31:0]   m1_wdata;
  logic          ctrl_arw_ready, ctrl_wready, ctrl_bvalid, ctrl_rvalid, ctrl_rlast;
  logic [31:0]   ctrl_rdata;

  logic          m0_arw_ready, m0_wready, m0_bvalid, m0_rvalid, m0_rlast;
  logic [31:0]   m0_rdata;
  logic          m1_arw_ready, m1_wready, m1_bvalid, m1_rvalid, m1_rlast;
  logic [31:0]   m1_rdata;
  logic          ctrl_arw_valid, ctrl_arw_write, ctrl_arw_id, ctrl_wvalid, ctrl_wlast;
  logic          ctrl_bready, ctrl_rready;
  logic [AB-1:0] ctrl_arw_addr;
  logic [7:0]    ctrl_arw_len;
  logic [31:0]   ctrl_wdata;

  logic          f_m0_arw_ready, f_m0_wready, f_m0_bvalid, f_m0_rvalid, f_m0_rlast;
  logic [31:0]   f_m0_rdata;
  logic          f_m1_arw_ready, f_m1_wready, f_m1_bvalid, f_m1_rvalid, f_m1_rlast;
  logic [31:0]   f_m1_rdata;
  logic          f_ctrl_arw_valid, f_ctrl_arw_write, f_ctrl_arw_id, f_ctrl_wvalid, f_ctrl_wlast;
  logic          f_ctrl_bready, f_ctrl_rready;
  logic [AB-1:0] f_ctrl_arw_addr;
  logic [7:0]    f_ctrl_arw_len;
  logic [31:0]   f_ctrl_wdata;

  ddr_port_arbiter #(.ADDR_BITS(AB), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .m0_arw_valid(m0_arw_valid), .m0_arw_ready(m0_arw_ready), .m0_arw_addr(m0_arw_addr),
    .m0_arw_len(m0_arw_len), .m0_arw_write(m0_arw_write), .m0_wvalid(m0_wvalid),
    .m0_wready(m0_wready), .m0_wlast(m0_wlast), .m0_wdata(m0_wdata), .m0_bvalid(m0_bvalid),
    .m0_bready(m0_bready), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rlast(m0_rlast),
    .m0_rdata(m0_rdata),
    .m1_arw_valid(m1_arw_valid), .m1_arw_ready(m1_arw_ready), .m1_arw_addr(m1_arw_addr),
    .m1_arw_len(m1_arw_len), .m1_arw_write(m1_arw_write), .m1_wvalid(m1_wvalid),
    .m1_wready(m1_wready), .m1_wlast(m1_wlast), .m1_wdata(m1_wdata), .m1_bvalid(m1_bvalid),
    .m1_bready(m1_bready), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rlast(m1_rlast),
    .m1_rdata(m1_rdata),
    .ctrl_arw_valid(ctrl_arw_valid), .ctrl_arw_ready(ctrl_arw_ready), .ctrl_arw_addr(ctrl_arw_addr),
    .ctrl_arw_len(ctrl_arw_len), .ctrl_arw_write(ctrl_arw_write), .ctrl_arw_id(ctrl_arw_id),
    .ctrl_wvalid(ctrl_wvalid), .ctrl_wready(ctrl_wready), .ctrl_wlast(ctrl_wlast),
    .ctrl_wdata(ctrl_wdata), .ctrl_bvalid(ctrl_bvalid), .ctrl_bready(ctrl_bready),
    .ctrl_rvalid(ctrl_rvalid), .ctrl_rready(ctrl_rready), .ctrl_rlast(ctrl_rlast),
    .ctrl_rdata(ctrl_rdata)
  );

  ddr_port_arbiter #(.ADDR_BITS(AB), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_arw_valid(m0_arw_valid), .m0_arw_ready(f_m0_arw_ready), .m0_arw_addr(m0_arw_addr),
    .m0_arw_len(m0_arw_len), .m0_arw_write(m0_arw_write), .m0_wvalid(m0_wvalid),
    .m0_wready(f_m0_wready), .m0_wlast(m0_wlast), .m0_wdata(m0_wdata), .m0_bvalid(f_m0_bvalid),
    .m0_bready(m0_bready), .m0_rvalid(f_m0_rvalid), .m0_rready(m0_rready), .m0_rlast(f_m0_rlast),
    .m0_rdata(f_m0_rdata),
    .m1_arw_valid(m1_arw_valid), .m1_arw_ready(f_m1_arw_ready), .m1_arw_addr(m1_arw_addr),
    .m1_arw_len(m1_arw_len), .m1_arw_write(m1_arw_write), .m1_wvalid(m1_wvalid),
    .m1_wready(f_m1_wready), .m1_wlast(m1_wlast), .m1_wdata(m1_wdata), .m1_bvalid(f_m1_bvalid),
    .m1_bready(m1_bready), .m1_rvalid(f_m1_rvalid), .m1_rready(m1_rready), .m1_rlast(f_m1_rlast),
    .m1_rdata(f_m1_rdata),
    .ctrl_arw_valid(f_ctrl_arw_valid), .ctrl_arw_ready(ctrl_arw_ready), .ctrl_arw_addr(f_ctrl_arw_addr),
    .ctrl_arw_len(f_ctrl_arw_len), .ctrl_arw_write(f_ctrl_arw_write), .ctrl_arw_id(f_ctrl_arw_id),
    .ctrl_wvalid(f_ctrl_wvalid), .ctrl_wready(ctrl_wready), .ctrl_wlast(f_ctrl_wlast),
    .ctrl_wdata(f_ctrl_wdata), .ctrl_bvalid(ctrl_bvalid), .ctrl_bready(f_ctrl_bready),
    .ctrl_rvalid(ctrl_rvalid), .ctrl_rready(f_ctrl_rready), .ctrl_rlast(ctrl_rlast),
    .ctrl_rdata(ctrl_rdata)
  );

  // Bit 7 is m1_arw_ready.
  wire [11:0] dut_vr  = {m0_arw_ready, m0_wready, m0_bvalid, m0_rvalid,
                         m1_arw_ready, m1_wready, m1_bvalid, m1_rvalid,
                         ctrl_arw_valid, ctrl_wvalid, ctrl_bready, ctrl_rready};
  wire [4:0]  m1_outs = {m1_arw_ready, m1_wready, m1_bvalid, m1_rvalid, m1_rlast};

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_arw_valid = 0; m0_arw_addr = '0; m0_arw_len = 0; m0_arw_write = 0;
    m0_wvalid = 0; m0_wlast = 0; m0_wdata = 0; m0_bready = 0; m0_rready = 0;
    m1_arw_valid = 0; m1_arw_addr = '0; m1_arw_len = 0; m1_arw_write = 0;
    m1_wvalid = 0; m1_wlast = 0; m1_wdata = 0; m1_bready = 0; m1_rready = 0;
    ctrl_arw_ready = 1; ctrl_wready = 1; ctrl_bvalid = 0; ctrl_rvalid = 0;
    ctrl_rlast = 0; ctrl_rdata = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    m0_arw_valid = 1; m1_arw_valid = 1;
    tick(); tick();
    vec_cnt++;
    if (dut_vr !== 12'h000) begin
      err_cnt++; $display("FAIL reset_hold_vr got=%h exp=000", dut_vr);
    end
    reset = 0;
    #1;
    vec_cnt++;
    if (dut_vr !== 12'h000 || f_m0_arw_ready !== 1'b0) begin
      err_cnt++; $display("FAIL reset_after_vr got=%h fp_m0_ready=%b exp=000/0", dut_vr, f_m0_arw_ready);
    end
    m0_arw_valid = 0; m1_arw_valid = 0;
    tick();
    $display("txn reset done");
  endtask

  task automatic test_m0_write();
    m0_arw_valid = 1; m0_arw_addr = 26'h0001000; m0_arw_len = 8'd3; m0_arw_write = 1;
    #1;
    vec_cnt++;
    if (m0_arw_ready !== 1'b1 || ctrl_arw_valid !== 1'b0) begin
      err_cnt++; $display("FAIL wr_idle_ready got=%b,%b exp=1,0", m0_arw_ready, ctrl_arw_valid);
    end
    tick();
    m0_arw_valid = 0;
    #1;
    vec_cnt++;
    if ({ctrl_arw_valid, ctrl_arw_addr, ctrl_arw_len, ctrl_arw_write, ctrl_arw_id}
        !== {1'b1, 26'h0001000, 8'd3, 1'b1, 1'b0}) begin
      err_cnt++; $display("FAIL wr_addr got v=%b a=%h l=%0d w=%b id=%b exp 1/0001000/3/1/0",
                          ctrl_arw_valid, ctrl_arw_addr, ctrl_arw_len, ctrl_arw_write, ctrl_arw_id);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      m0_wvalid = 1; m0_wdata = 32'(8'h11 * (i + 1)); m0_wlast = (i == 3);
      #1;
      vec_cnt++;
      if ({ctrl_wvalid, ctrl_wlast, ctrl_wdata, m0_wready} !==
          {1'b1, (i == 3), 32'(8'h11 * (i + 1)), 1'b1} || m1_outs !== 5'b0) begin
        err_cnt++; $display("FAIL wr_beat%0d got v=%b last=%b d=%h rdy=%b m1=%b exp d=%h",
                            i, ctrl_wvalid, ctrl_wlast, ctrl_wdata, m0_wready, m1_outs,
                            32'(8'h11 * (i + 1)));
      end
      tick();
    end
    m0_wvalid = 0; m0_wlast = 0;
    ctrl_bvalid = 1; m0_bready = 1;
    #1;
    vec_cnt++;
    if ({m0_bvalid, ctrl_bready, m1_outs} !== {1'b1, 1'b1, 5'b0}) begin
      err_cnt++; $display("FAIL wr_bresp got bv=%b br=%b m1=%b exp 1,1,0", m0_bvalid, ctrl_bready, m1_outs);
    end
    tick();
    ctrl_bvalid = 0; m0_bready = 0;
    #1;
    vec_cnt++;
    if ({m0_bvalid, m1_outs} !== 6'b0) begin
      err_cnt++; $display("FAIL wr_after_b got bv=%b m1=%b exp 0", m0_bvalid, m1_outs);
    end
    $display("txn m0 write len=3 done");
  endtask

  task automatic test_m1_read();
    m1_arw_valid = 1; m1_arw_addr = 26'h2ABCDE0; m1_arw_len = 8'd7; m1_arw_write = 0; m1_rready = 1;
    #1;
    vec_cnt++;
    if ({m0_arw_ready, m1_arw_ready} !== 2'b01) begin
      err_cnt++; $display("FAIL rd_idle_ready got m0=%b m1=%b exp 0,1", m0_arw_ready, m1_arw_ready);
    end
    tick();
    m1_arw_valid = 0;
    #1;
    vec_cnt++;
    if ({ctrl_arw_valid, ctrl_arw_addr, ctrl_arw_len, ctrl_arw_write, ctrl_arw_id}
        !== {1'b1, 26'h2ABCDE0, 8'd7, 1'b0, 1'b1}) begin
      err_cnt++; $display("FAIL rd_addr got v=%b a=%h l=%0d w=%b id=%b exp 1/2abcde0/7/0/1",
                          ctrl_arw_valid, ctrl_arw_addr, ctrl_arw_len, ctrl_arw_write, ctrl_arw_id);
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      ctrl_rvalid = 1; ctrl_rlast = (i == 7); ctrl_rdata = 32'hA000_0000 + 32'(i);
      #1;
      vec_cnt++;
      if ({m1_rvalid, m1_rlast, m1_rdata, m0_rvalid, ctrl_rready} !==
          {1'b1, (i == 7), 32'hA000_0000 + 32'(i), 1'b0, 1'b1}) begin
        err_cnt++; $display("FAIL rd_beat%0d got v=%b last=%b d=%h m0v=%b rr=%b",
                            i, m1_rvalid, m1_rlast, m1_rdata, m0_rvalid, ctrl_rready);
      end
      tick();
    end
    ctrl_rvalid = 0; ctrl_rlast = 0; m1_rready = 0;
    #1;
    vec_cnt++;
    if (dut_vr !== 12'h000) begin
      err_cnt++; $display("FAIL rd_back_idle got=%h exp=000", dut_vr);
    end
    $display("txn m1 read len=7 done");
  endtask

  task automatic test_contention();
    m0_arw_valid = 1; m0_arw_addr = 26'h100; m0_arw_len = 0; m0_arw_write = 0;
    m1_arw_valid = 1; m1_arw_addr = 26'h200; m1_arw_len = 0; m1_arw_write = 0;
    ctrl_rvalid = 1; ctrl_rlast = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vec_cnt++;
      if ({m0_arw_ready, m1_arw_ready} !== {(k % 2 == 0), (k % 2 == 1)} ||
          {f_m0_arw_ready, f_m1_arw_ready} !== 2'b10) begin
        err_cnt++; $display("FAIL contend%0d got rr=%b%b fp=%b%b", k, m0_arw_ready, m1_arw_ready,
                            f_m0_arw_ready, f_m1_arw_ready);
      end
      tick();
      vec_cnt++;
      if ({ctrl_arw_valid, ctrl_arw_id, ctrl_arw_addr} !==
          {1'b1, (k % 2 == 1), (k % 2 == 0) ? 26'h100 : 26'h200} || f_ctrl_arw_id !== 1'b0) begin
        err_cnt++; $display("FAIL contend%0d_addr got v=%b id=%b a=%h fp_id=%b", k, ctrl_arw_valid,
                            ctrl_arw_id, ctrl_arw_addr, f_ctrl_arw_id);
      end
      tick();
      tick();
    end
    clear_inputs();
    $display("txn contention x4 done");
  endtask

  task automatic test_wlen_overflow();
    m0_arw_valid = 1; m0_arw_addr = 26'h300; m0_arw_len = 8'd1; m0_arw_write = 1;
    #1;
    vec_cnt++;
    if (m0_arw_ready !== 1'b1) begin
      err_cnt++; $display("FAIL ovf_ready got=%b exp=1", m0_arw_ready);
    end
    tick();
    m0_arw_valid = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      m0_wvalid = 1; m0_wlast = 0; m0_wdata = 32'h55 + 32'(i) * 32'h11;
      #1;
      vec_cnt++;
      if ({ctrl_wvalid, m0_wready} !== ((i < 2) ? 2'b11 : 2'b00)) begin
        err_cnt++; $display("FAIL ovf_beat%0d got v=%b rdy=%b exp %b", i, ctrl_wvalid, m0_wready,
                            (i < 2) ? 2'b11 : 2'b00);
      end
      if (i < 2) tick();
    end
    m0_wvalid = 0;
    $display("txn m0 write len=1 with extra beat done");
  endtask

  task automatic test_bready_stall();
    m1_arw_valid = 1; m1_arw_addr = 26'h400; m1_arw_len = 0; m1_arw_write = 0;
    ctrl_bvalid = 1; m0_bready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vec_cnt++;
      if ({m0_bvalid, ctrl_bready, m1_arw_ready} !== 3'b100) begin
        err_cnt++; $display("FAIL stall%0d got bv=%b br=%b m1rdy=%b exp 1,0,0", i, m0_bvalid,
                            ctrl_bready, m1_arw_ready);
      end
      tick();
    end
    m0_bready = 1;
    #1;
    vec_cnt++;
    if ({ctrl_bready, m1_arw_ready} !== 2'b10) begin
      err_cnt++; $display("FAIL stall_hs got br=%b m1rdy=%b exp 1,0", ctrl_bready, m1_arw_ready);
    end
    tick();
    ctrl_bvalid = 0; m0_bready = 0;
    #1;
    vec_cnt++;
    if (m1_arw_ready !== 1'b1) begin
      err_cnt++; $display("FAIL stall_next_grant got=%b exp=1", m1_arw_ready);
    end
    tick();
    m1_arw_valid = 0;
    #1;
    vec_cnt++;
    if ({ctrl_arw_valid, ctrl_arw_id, ctrl_arw_addr} !== {1'b1, 1'b1, 26'h400}) begin
      err_cnt++; $display("FAIL stall_addr got v=%b id=%b a=%h exp 1,1,400", ctrl_arw_valid,
                          ctrl_arw_id, ctrl_arw_addr);
    end
    tick();
    ctrl_rvalid = 1; ctrl_rlast = 1; ctrl_rdata = 32'hDEAD_BEEF;
    #1;
    vec_cnt++;
    if ({m1_rvalid, m1_rlast, m1_rdata} !== {1'b1, 1'b1, 32'hDEAD_BEEF}) begin
      err_cnt++; $display("FAIL stall_rd got v=%b l=%b d=%h", m1_rvalid, m1_rlast, m1_rdata);
    end
    tick();
    clear_inputs();
    $display("txn bready stall then m1 read done");
  endtask

  task automatic test_reset_mid();
    m0_arw_valid = 1; m0_arw_addr = 26'h500; m0_arw_len = 8'd3; m0_arw_write = 1;
    tick();
    m0_arw_valid = 0;
    tick();
    m0_wvalid = 1; m0_wdata = 32'h1; tick();
    m0_wdata = 32'h2; tick();
    m0_wdata = 32'h3; reset = 1;
    m1_arw_valid = 1; m1_arw_addr = 26'h600; m1_arw_len = 0; m1_arw_write = 0;
    #1;
    vec_cnt++;
    if (dut_vr !== 12'h000) begin
      err_cnt++; $display("FAIL rstmid_hold got=%h exp=000", dut_vr);
    end
    tick();
    reset = 0; m0_wvalid = 0;
    #1;
    vec_cnt++;
    if (dut_vr !== 12'h000) begin
      err_cnt++; $display("FAIL rstmid_after got=%h exp=000", dut_vr);
    end
    tick();
    vec_cnt++;
    if (dut_vr !== 12'h080) begin
      err_cnt++; $display("FAIL rstmid_grant got=%h exp=080", dut_vr);
    end
    tick();
    m1_arw_valid = 0;
    #1;
    vec_cnt++;
    if ({ctrl_arw_valid, ctrl_arw_id, ctrl_arw_write, ctrl_arw_addr} !== {1'b1, 1'b1, 1'b0, 26'h600}) begin
      err_cnt++; $display("FAIL rstmid_addr got v=%b id=%b w=%b a=%h exp 1,1,0,600", ctrl_arw_valid,
                          ctrl_arw_id, ctrl_arw_write, ctrl_arw_addr);
    end
    tick();
    ctrl_rvalid = 1; ctrl_rlast = 1;
    #1;
    vec_cnt++;
    if ({m1_rvalid, m0_rvalid} !== 2'b10) begin
      err_cnt++; $display("FAIL rstmid_rd got m1v=%b m0v=%b exp 1,0", m1_rvalid, m0_rvalid);
    end
    tick();
    clear_inputs();
    $display("txn reset mid-write then m1 read done");
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_m0_write();
    test_m1_read();
    test_contention();
    test_wlen_overflow();
    test_bready_stall();
    test_reset_mid();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
